// File: rtl/esp_dma_pkg.sv
`default_nettype none
// ============================================================================
// esp_dma_pkg : shared types and constants for the ESP DMA responder
// Rev 1.0
// ============================================================================
package esp_dma_pkg;

  localparam int         DMA_WORD_W  = 64;
  localparam logic [2:0] DMA_SIZE_64 = 3'b011;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_STREAM = 2'd1
  } rd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_STREAM = 2'd1
  } wr_state_e;

  // A request is flagged when its beat size is not 64-bit or it runs past the end of memory.
  function automatic logic ctrl_bad(input logic [2:0] size, input logic [31:0] index,
                                    input logic [31:0] length, input int unsigned words);
    return (size != DMA_SIZE_64) || (({1'b0, index} + {1'b0, length}) > 33'(words));
  endfunction

endpackage
`default_nettype wire

// File: rtl/esp_dma_skid.sv
`default_nettype none
// ============================================================================
// esp_dma_skid : 2-entry valid/ready output buffer for read data
// Rev 1.0
// ============================================================================
module esp_dma_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         full,
  output logic         almost_full,
  output logic [1:0]   count
);

  logic [W-1:0] entry0;
  logic [W-1:0] entry1;
  logic         wptr;
  logic         rptr;
  logic [1:0]   cnt;
  logic         pop_fire;
  logic         push_fire;

  assign pop_fire    = pop && (cnt != 2'd0);
  assign push_fire   = push && ((cnt != 2'd2) || pop_fire);
  assign valid       = (cnt != 2'd0);
  assign data        = rptr ? entry1 : entry0;
  assign full        = (cnt == 2'd2);
  assign almost_full = (cnt == 2'd1);
  assign count       = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry0 <= '0;
      entry1 <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push_fire) begin
        if (wptr) entry1 <= push_data;
        else      entry0 <= push_data;
        wptr <= ~wptr;
      end
      if (pop_fire) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push_fire} - {1'b0, pop_fire};
    end
  end

endmodule
`default_nettype wire

// File: rtl/esp_dma_responder.sv
`default_nettype none
// ============================================================================
// esp_dma_responder : ESP dma_read/dma_write target backed by a 64-bit word memory
// Rev 1.0
// ============================================================================
module esp_dma_responder
  import esp_dma_pkg::*;
#(
  parameter  int MEM_WORDS = 8192,
  localparam int AW        = $clog2(MEM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_read_ctrl_valid,
  output logic                  dma_read_ctrl_ready,
  input  logic [31:0]           dma_read_ctrl_data_index,
  input  logic [31:0]           dma_read_ctrl_data_length,
  input  logic [2:0]            dma_read_ctrl_data_size,
  input  logic [5:0]            dma_read_ctrl_data_user,
  output logic                  dma_read_chnl_valid,
  input  logic                  dma_read_chnl_ready,
  output logic [DMA_WORD_W-1:0] dma_read_chnl_data,
  input  logic                  dma_write_ctrl_valid,
  output logic                  dma_write_ctrl_ready,
  input  logic [31:0]           dma_write_ctrl_data_index,
  input  logic [31:0]           dma_write_ctrl_data_length,
  input  logic [2:0]            dma_write_ctrl_data_size,
  input  logic [5:0]            dma_write_ctrl_data_user,
  input  logic                  dma_write_chnl_valid,
  output logic                  dma_write_chnl_ready,
  input  logic [DMA_WORD_W-1:0] dma_write_chnl_data,
  input  logic                  host_we,
  input  logic [AW-1:0]         host_addr,
  input  logic [DMA_WORD_W-1:0] host_wdata,
  output logic                  host_ready,
  output logic                  err,
  input  logic                  err_clr,
  output logic [31:0]           debug
);

  logic [DMA_WORD_W-1:0] mem [MEM_WORDS];

  rd_state_e             rd_state;
  logic [AW-1:0]         rd_index;
  logic [31:0]           rd_length;
  logic [31:0]           rd_issued;
  logic [31:0]           rd_cnt;
  logic                  rd_pending;
  logic [DMA_WORD_W-1:0] mem_rdata;
  logic                  rd_hs;
  logic                  rd_pop;
  logic                  rd_issue;
  logic                  rd_last;
  logic [AW-1:0]         rd_addr;
  logic [1:0]            skid_count;
  logic [2:0]            rd_occupancy;
  logic                  skid_full;
  logic                  skid_almost_full;

  wr_state_e             wr_state;
  logic [AW-1:0]         wr_index;
  logic [31:0]           wr_length;
  logic [31:0]           wr_cnt;
  logic                  wr_hs;
  logic                  wr_beat;
  logic                  wr_last;

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DMA_WORD_W-1:0] mem_wdata;
  logic                  err_set;
  logic                  unused_ok;

  assign unused_ok = ^{dma_read_ctrl_data_user, dma_write_ctrl_data_user,
                       skid_full, skid_almost_full};

  // ---------------------------------------------------------------- read side
  assign rd_hs        = dma_read_ctrl_valid && dma_read_ctrl_ready;
  assign rd_pop       = dma_read_chnl_valid && dma_read_chnl_ready;
  assign rd_addr      = rd_index + rd_issued[AW-1:0];
  assign rd_occupancy = {2'b00, rd_pending} + {1'b0, skid_count};
  // A pop this cycle frees a slot, so issuing alongside it keeps one beat per cycle.
  assign rd_issue     = (rd_state == RD_STREAM) && (rd_issued != rd_length) &&
                        (rd_occupancy < (3'd2 + {2'b00, rd_pop}));
  assign rd_last      = rd_pop && (rd_cnt == (rd_length - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state            <= RD_IDLE;
      dma_read_ctrl_ready <= 1'b0;
      rd_index            <= '0;
      rd_length           <= '0;
      rd_issued           <= '0;
      rd_cnt              <= '0;
      rd_pending          <= 1'b0;
    end else begin
      rd_pending <= rd_issue;
      case (rd_state)
        RD_IDLE: begin
          dma_read_ctrl_ready <= 1'b1;
          if (rd_hs) begin
            rd_index  <= dma_read_ctrl_data_index[AW-1:0];
            rd_length <= dma_read_ctrl_data_length;
            rd_issued <= '0;
            rd_cnt    <= '0;
            if (dma_read_ctrl_data_length != 32'd0) begin
              rd_state            <= RD_STREAM;
              dma_read_ctrl_ready <= 1'b0;
            end
          end
        end
        RD_STREAM: begin
          if (rd_issue) rd_issued <= rd_issued + 32'd1;
          if (rd_pop)   rd_cnt    <= rd_cnt + 32'd1;
          if (rd_last) begin
            rd_state            <= RD_IDLE;
            dma_read_ctrl_ready <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd_issue) mem_rdata <= mem[rd_addr];
  end

  esp_dma_skid #(
    .W (DMA_WORD_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push        (rd_pending),
    .push_data   (mem_rdata),
    .pop         (dma_read_chnl_ready),
    .valid       (dma_read_chnl_valid),
    .data        (dma_read_chnl_data),
    .full        (skid_full),
    .almost_full (skid_almost_full),
    .count       (skid_count)
  );

  // --------------------------------------------------------------- write side
  assign wr_hs   = dma_write_ctrl_valid && dma_write_ctrl_ready;
  assign wr_beat = (wr_state == WR_STREAM) && dma_write_chnl_valid && dma_write_chnl_ready;
  assign wr_last = wr_beat && (wr_cnt == (wr_length - 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state             <= WR_IDLE;
      dma_write_ctrl_ready <= 1'b0;
      dma_write_chnl_ready <= 1'b0;
      host_ready           <= 1'b0;
      wr_index             <= '0;
      wr_length            <= '0;
      wr_cnt               <= '0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          dma_write_ctrl_ready <= 1'b1;
          dma_write_chnl_ready <= 1'b0;
          host_ready           <= 1'b1;
          if (wr_hs) begin
            wr_index  <= dma_write_ctrl_data_index[AW-1:0];
            wr_length <= dma_write_ctrl_data_length;
            wr_cnt    <= '0;
            if (dma_write_ctrl_data_length != 32'd0) begin
              wr_state             <= WR_STREAM;
              dma_write_ctrl_ready <= 1'b0;
              dma_write_chnl_ready <= 1'b1;
              host_ready           <= 1'b0;
            end
          end
        end
        WR_STREAM: begin
          if (wr_beat) wr_cnt <= wr_cnt + 32'd1;
          if (wr_last) begin
            wr_state             <= WR_IDLE;
            dma_write_ctrl_ready <= 1'b1;
            dma_write_chnl_ready <= 1'b0;
            host_ready           <= 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // host_ready is low whenever a DMA write burst owns the port, so the two never collide.
  assign mem_we    = wr_beat || (host_we && host_ready);
  assign mem_waddr = wr_beat ? (wr_index + wr_cnt[AW-1:0]) : host_addr;
  assign mem_wdata = wr_beat ? dma_write_chnl_data : host_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------- status
  assign err_set = (rd_hs && ctrl_bad(dma_read_ctrl_data_size, dma_read_ctrl_data_index,
                                      dma_read_ctrl_data_length, MEM_WORDS)) ||
                   (wr_hs && ctrl_bad(dma_write_ctrl_data_size, dma_write_ctrl_data_index,
                                      dma_write_ctrl_data_length, MEM_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err <= 1'b0;
    else if (err_set) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

  assign debug = {28'd0, wr_state, rd_state};

endmodule
`default_nettype wire
